// File: rtl/cv32e40p_ft_spare_voter.sv
// ---------------------------------------------------------------------------
// cv32e40p_ft_spare_voter
//
// Fault-tolerance controller for a bank of NUM_REPL identical functional-unit
// replicas (ALU, MULT, ...). Three "slots" feed a word-level majority vote.
// Every replica in a slot keeps a disagreement counter. When a counter reaches
// THRESH, that replica is marked permanently faulty. The controller then swaps
// a healthy spare into its slot. When no spare is left, it falls back to a
// duplex, detect-only mode. Replicas outside the active slots have their clock
// enables dropped.
//
// Ports
//   clk              clock
//   rst              synchronous, active-high reset
//   valid_i          replica results are valid this cycle (one vote)
//   result_i         replica r result at [r*DATA_W +: DATA_W]
//   voted_o          registered voted result (holds when no vote)
//   voted_valid_o    voted_o carries a fresh vote
//   err_detected_o   an active slot disagreed on the last vote
//   err_corrected_o  a 2-of-3 majority masked the disagreement
//   err_uncorr_o     no majority (3-way differ, duplex mismatch, or FAIL)
//   replica_en_o     per-replica clock enable (1 = occupies an active slot)
//   faulty_o         sticky permanent-fault mask
//   err_cnt_o        per-replica error counters, CNT_W bits each
//   state_o          00 TMR, 01 SWAP, 10 DUPLEX, 11 FAIL
// ---------------------------------------------------------------------------
module cv32e40p_ft_spare_voter #(
  parameter int NUM_REPL = 4,
  parameter int DATA_W   = 32,
  parameter int THRESH   = 8,
  parameter int CNT_W    = $clog2(THRESH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [NUM_REPL*DATA_W-1:0] result_i,
  output logic [DATA_W-1:0]          voted_o,
  output logic                       voted_valid_o,
  output logic                       err_detected_o,
  output logic                       err_corrected_o,
  output logic                       err_uncorr_o,
  output logic [NUM_REPL-1:0]        replica_en_o,
  output logic [NUM_REPL-1:0]        faulty_o,
  output logic [NUM_REPL*CNT_W-1:0]  err_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int SW = (NUM_REPL > 1) ? $clog2(NUM_REPL) : 1;
  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    ST_TMR    = 2'b00,
    ST_SWAP   = 2'b01,
    ST_DUPLEX = 2'b10,
    ST_FAIL   = 2'b11
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_slot [3];
  logic [SW-1:0]       w_slot_nxt [3];
  logic [NUM_REPL-1:0] r_faulty, w_faulty_nxt, w_new_faulty;
  logic [CNT_W-1:0]    r_cnt [NUM_REPL];
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_REPL];
  logic [DATA_W-1:0]   r_voted, w_voted_nxt;
  logic                r_vvalid, r_det, r_cor, r_unc;
  logic                w_det_nxt, w_cor_nxt, w_unc_nxt;

  logic [DATA_W-1:0]   w_res [NUM_REPL];
  logic [DATA_W-1:0]   w_a, w_b, w_c;
  logic                w_eq01, w_eq02, w_eq12, w_major;
  logic [2:0]          w_dissent;

  logic                w_fslot_vld, w_spare_vld, w_pending;
  logic [1:0]          w_fslot;
  logic [SW-1:0]       w_spare, w_h0, w_h1;
  logic [SW:0]         w_healthy_cnt;

  for (genvar g = 0; g < NUM_REPL; g++) begin : g_repl
    assign w_res[g] = result_i[g*DATA_W +: DATA_W];
    assign err_cnt_o[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign w_a    = w_res[r_slot[0]];
  assign w_b    = w_res[r_slot[1]];
  assign w_c    = w_res[r_slot[2]];
  assign w_eq01 = (w_a == w_b);
  assign w_eq02 = (w_a == w_c);
  assign w_eq12 = (w_b == w_c);
  assign w_major = w_eq01 | w_eq02 | w_eq12;

  // Bit k marks slot k as the lone dissenter. It stays empty when all three
  // slots agree, and also when all three differ.
  always_comb begin
    w_dissent = 3'b000;
    if (w_eq01 && !w_eq02)      w_dissent = 3'b100;
    else if (w_eq02 && !w_eq01) w_dissent = 3'b010;
    else if (w_eq12 && !w_eq01) w_dissent = 3'b001;
  end

  // Vote, flags and counters. Faulty replicas still parked in a slot during
  // SWAP take part in the vote, but they are never counted.
  always_comb begin
    w_voted_nxt  = r_voted;
    w_det_nxt    = 1'b0;
    w_cor_nxt    = 1'b0;
    w_unc_nxt    = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_new_faulty = '0;
    if (valid_i) begin
      case (r_state)
        ST_TMR, ST_SWAP: begin
          w_voted_nxt = (w_eq12 && !w_eq01) ? w_b : w_a;
          if (!w_major) begin
            w_det_nxt = 1'b1;
            w_unc_nxt = 1'b1;
          end else begin
            w_det_nxt = |w_dissent;
            w_cor_nxt = |w_dissent;
            for (int k = 0; k < 3; k++) begin
              if (!r_faulty[r_slot[k]]) begin
                if (w_dissent[k]) begin
                  if (r_cnt[r_slot[k]] != TH)
                    w_cnt_nxt[r_slot[k]] = r_cnt[r_slot[k]] + 1'b1;
                end else if (r_cnt[r_slot[k]] != '0) begin
                  w_cnt_nxt[r_slot[k]] = r_cnt[r_slot[k]] - 1'b1;
                end
                if (w_cnt_nxt[r_slot[k]] == TH) w_new_faulty[r_slot[k]] = 1'b1;
              end
            end
          end
        end
        default: begin
          w_voted_nxt = w_a;
          if (r_state == ST_DUPLEX && !w_eq01) begin
            w_det_nxt = 1'b1;
            w_unc_nxt = 1'b1;
          end
        end
      endcase
    end
    w_faulty_nxt = r_faulty | w_new_faulty;
  end

  // Swap bookkeeping. Lowest faulty slot, lowest healthy spare, whether
  // another slot still needs a swap, and the two lowest healthy replicas
  // for the duplex fallback.
  always_comb begin
    w_fslot_vld = 1'b0;
    w_fslot     = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (r_faulty[r_slot[k]]) begin
        w_fslot_vld = 1'b1;
        w_fslot     = 2'(k);
      end
    end
    w_spare_vld = 1'b0;
    w_spare     = '0;
    for (int r = NUM_REPL - 1; r >= 0; r--) begin
      if (!r_faulty[r] && r_slot[0] != SW'(r) && r_slot[1] != SW'(r) &&
          r_slot[2] != SW'(r)) begin
        w_spare_vld = 1'b1;
        w_spare     = SW'(r);
      end
    end
    w_pending = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) != w_fslot && w_faulty_nxt[r_slot[k]]) w_pending = 1'b1;
    end
    w_healthy_cnt = '0;
    w_h0          = '0;
    w_h1          = '0;
    for (int r = 0; r < NUM_REPL; r++) begin
      if (!w_faulty_nxt[r]) begin
        if (w_healthy_cnt == '0)                  w_h0 = SW'(r);
        else if (w_healthy_cnt == (SW+1)'(1))     w_h1 = SW'(r);
        w_healthy_cnt = w_healthy_cnt + 1'b1;
      end
    end
  end

  // Next state and slot mapping. Each SWAP cycle repairs one slot.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    case (r_state)
      ST_TMR: if (|w_new_faulty) w_state_nxt = ST_SWAP;
      ST_SWAP: begin
        if (!w_fslot_vld) begin
          w_state_nxt = ST_TMR;
        end else if (w_spare_vld) begin
          w_slot_nxt[w_fslot] = w_spare;
          w_state_nxt = w_pending ? ST_SWAP : ST_TMR;
        end else if (w_healthy_cnt >= (SW+1)'(2)) begin
          w_slot_nxt[0] = w_h0;
          w_slot_nxt[1] = w_h1;
          w_state_nxt   = ST_DUPLEX;
        end else begin
          if (w_healthy_cnt == (SW+1)'(1)) w_slot_nxt[0] = w_h0;
          w_state_nxt = ST_FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_TMR;
      r_slot[0] <= SW'(0);
      r_slot[1] <= SW'(1);
      r_slot[2] <= SW'(2);
      r_faulty <= '0;
      for (int r = 0; r < NUM_REPL; r++) r_cnt[r] <= '0;
      r_voted  <= '0;
      r_vvalid <= 1'b0;
      r_det    <= 1'b0;
      r_cor    <= 1'b0;
      r_unc    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_faulty <= w_faulty_nxt;
      r_cnt    <= w_cnt_nxt;
      r_voted  <= w_voted_nxt;
      r_vvalid <= valid_i;
      r_det    <= w_det_nxt;
      r_cor    <= w_cor_nxt;
      r_unc    <= w_unc_nxt;
    end
  end

  // Only the slots that feed the vote are clocked. Slot2 is idle in duplex.
  always_comb begin
    replica_en_o            = '0;
    replica_en_o[r_slot[0]] = 1'b1;
    replica_en_o[r_slot[1]] = 1'b1;
    if (r_state == ST_TMR || r_state == ST_SWAP) replica_en_o[r_slot[2]] = 1'b1;
  end

  assign voted_o         = r_voted;
  assign voted_valid_o   = r_vvalid;
  assign err_detected_o  = r_det;
  assign err_corrected_o = r_cor;
  assign err_uncorr_o    = r_unc | (r_state == ST_FAIL);
  assign faulty_o        = r_faulty;
  assign state_o         = r_state;

endmodule

// File: tb/tb_cv32e40p_ft_spare_voter.sv
module tb_cv32e40p_ft_spare_voter;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TH  = 8;
  localparam int CW  = $clog2(TH + 1);
  localparam int NRB = 5;
  localparam int THB = 1;
  localparam int CWB = $clog2(THB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, valid;
  logic [NR*DW-1:0] result;
  logic [DW-1:0]    voted;
  logic             vvalid, det, cor, unc;
  logic [NR-1:0]    en, faulty;
  logic [NR*CW-1:0] cnt;
  logic [1:0]       st;

  logic              rst_b, valid_b;
  logic [NRB*DW-1:0] result_b;
  logic [DW-1:0]     voted_b;
  logic              vvalid_b, det_b, cor_b, unc_b;
  logic [NRB-1:0]    en_b, faulty_b;
  logic [NRB*CWB-1:0] cnt_b;
  logic [1:0]        st_b;

  cv32e40p_ft_spare_voter #(.NUM_REPL(NR), .DATA_W(DW), .THRESH(TH)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid), .result_i(result),
    .voted_o(voted), .voted_valid_o(vvalid), .err_detected_o(det),
    .err_corrected_o(cor), .err_uncorr_o(unc), .replica_en_o(en),
    .faulty_o(faulty), .err_cnt_o(cnt), .state_o(st));

  cv32e40p_ft_spare_voter #(.NUM_REPL(NRB), .DATA_W(DW), .THRESH(THB)) u_dut_b (
    .clk(clk), .rst(rst_b), .valid_i(valid_b), .result_i(result_b),
    .voted_o(voted_b), .voted_valid_o(vvalid_b), .err_detected_o(det_b),
    .err_corrected_o(cor_b), .err_uncorr_o(unc_b), .replica_en_o(en_b),
    .faulty_o(faulty_b), .err_cnt_o(cnt_b), .state_o(st_b));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_a(input bit r, input bit v, input logic [NR*DW-1:0] res);
    rst = r; valid = v; result = res;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input bit r, input bit v, input logic [NRB*DW-1:0] res);
    rst_b = r; valid_b = v; result_b = res;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model (DUT A) ----------------
  int            m_slot [3];
  bit            m_faulty [NR];
  int            m_cnt [NR];
  int            m_state;
  logic [DW-1:0] m_voted;
  bit            m_vv, m_det, m_cor, m_unc;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) m_slot[k] = k;
    for (int r = 0; r < NR; r++) begin m_faulty[r] = 0; m_cnt[r] = 0; end
    m_state = 0; m_voted = '0;
    m_vv = 0; m_det = 0; m_cor = 0; m_unc = 0;
  endfunction

  function automatic void model_step(input bit r, input bit v, input logic [NR*DW-1:0] res);
    logic [DW-1:0] vs [3];
    bit newf [NR];
    bit fnext [NR];
    int maj_k, st_n, fk, sp, agree, rp;
    int hq [$];
    if (r) begin model_reset(); return; end
    m_vv = v; m_det = 0; m_cor = 0; m_unc = 0;
    for (int i = 0; i < NR; i++) newf[i] = 0;
    if (v) begin
      for (int k = 0; k < 3; k++) vs[k] = res[m_slot[k]*DW +: DW];
      if (m_state <= 1) begin
        maj_k = -1;
        for (int k = 0; k < 3; k++) begin
          agree = 0;
          for (int j = 0; j < 3; j++) if (vs[j] == vs[k]) agree++;
          if (agree >= 2 && maj_k < 0) maj_k = k;
        end
        if (maj_k < 0) begin
          m_voted = vs[0]; m_det = 1; m_unc = 1;
        end else begin
          m_voted = vs[maj_k];
          for (int k = 0; k < 3; k++) begin
            rp = m_slot[k];
            if (vs[k] != vs[maj_k]) begin m_det = 1; m_cor = 1; end
            if (!m_faulty[rp]) begin
              if (vs[k] != vs[maj_k]) m_cnt[rp] = (m_cnt[rp] + 1 > TH) ? TH : m_cnt[rp] + 1;
              else                    m_cnt[rp] = (m_cnt[rp] > 0) ? m_cnt[rp] - 1 : 0;
              if (m_cnt[rp] == TH) newf[rp] = 1;
            end
          end
        end
      end else begin
        m_voted = vs[0];
        if (m_state == 2 && vs[0] != vs[1]) begin m_det = 1; m_unc = 1; end
      end
    end
    for (int i = 0; i < NR; i++) fnext[i] = m_faulty[i] | newf[i];
    st_n = m_state;
    if (m_state == 0) begin
      for (int i = 0; i < NR; i++) if (newf[i]) st_n = 1;
    end else if (m_state == 1) begin
      fk = -1;
      for (int k = 0; k < 3; k++) if (fk < 0 && m_faulty[m_slot[k]]) fk = k;
      if (fk < 0) st_n = 0;
      else begin
        sp = -1;
        for (int q = 0; q < NR; q++)
          if (sp < 0 && !m_faulty[q] && q != m_slot[0] && q != m_slot[1] && q != m_slot[2]) sp = q;
        if (sp >= 0) begin
          m_slot[fk] = sp;
          st_n = 0;
          for (int k = 0; k < 3; k++) if (fnext[m_slot[k]]) st_n = 1;
        end else begin
          for (int q = 0; q < NR; q++) if (!fnext[q]) hq.push_back(q);
          if (hq.size() >= 2) begin m_slot[0] = hq[0]; m_slot[1] = hq[1]; st_n = 2; end
          else begin
            if (hq.size() == 1) m_slot[0] = hq[0];
            st_n = 3;
          end
        end
      end
    end
    for (int i = 0; i < NR; i++) m_faulty[i] = fnext[i];
    m_state = st_n;
  endfunction

  task automatic cmp_model(input int cyc);
    logic [NR-1:0]    e_en, e_f;
    logic [NR*CW-1:0] e_c;
    e_en = '0;
    e_en[m_slot[0]] = 1'b1;
    e_en[m_slot[1]] = 1'b1;
    if (m_state < 2) e_en[m_slot[2]] = 1'b1;
    for (int r = 0; r < NR; r++) begin
      e_f[r] = m_faulty[r];
      e_c[r*CW +: CW] = CW'(m_cnt[r]);
    end
    check($sformatf("rnd%0d.voted", cyc), 64'(voted), 64'(m_voted));
    check($sformatf("rnd%0d.flags", cyc), 64'({vvalid, det, cor, unc}),
          64'({m_vv, m_det, m_cor, m_unc | (m_state == 3)}));
    check($sformatf("rnd%0d.state", cyc), 64'(st), 64'(m_state[1:0]));
    check($sformatf("rnd%0d.en", cyc), 64'(en), 64'(e_en));
    check($sformatf("rnd%0d.faulty", cyc), 64'(faulty), 64'(e_f));
    check($sformatf("rnd%0d.cnt", cyc), 64'(cnt), 64'(e_c));
  endtask

  // ---------------- directed vector table (DUT A) ----------------
  typedef struct {
    bit               rst, vld;
    logic [NR*DW-1:0] res;
    logic [DW-1:0]    voted;
    bit               vv, det, cor, unc;
    logic [1:0]       st;
    logic [NR-1:0]    en, f;
    logic [NR*CW-1:0] cnt;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(input bit rs, input bit v,
      input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
      input logic [31:0] vo, input bit vv, input bit d, input bit c, input bit u,
      input logic [1:0] s, input logic [3:0] e, input logic [3:0] f, input logic [15:0] n);
    vec_t x;
    x.rst = rs; x.vld = v; x.res = {r3, r2, r1, r0};
    x.voted = vo; x.vv = vv; x.det = d; x.cor = c; x.unc = u;
    x.st = s; x.en = e; x.f = f; x.cnt = n;
    tbl.push_back(x);
  endfunction

  localparam logic [31:0] A5 = 32'hA5A5A5A5;

  initial begin
    logic [NR*DW-1:0]  res;
    logic [NRB*DW-1:0] rb1, rb2;
    logic [31:0]       base;
    int                bad;
    bit                v, r;

    rst = 1; valid = 0; result = '0;
    rst_b = 1; valid_b = 0; result_b = '0;

    add(1,0, 0,0,0,0, 0,0,0,0,0, 2'd0, 4'b0111, 4'b0000, 16'h0000);
    for (int i = 0; i < 3; i++)
      add(0,1, A5,A5,A5,A5, A5,1,0,0,0, 2'd0, 4'b0111, 4'b0000, 16'h0000);
    add(0,1, A5,32'hFFFFFFFF,A5,A5, A5,1,1,1,0, 2'd0, 4'b0111, 4'b0000, 16'h0010);
    add(0,1, A5,A5,A5,A5, A5,1,0,0,0, 2'd0, 4'b0111, 4'b0000, 16'h0000);
    add(0,0, 0,0,0,0, A5,0,0,0,0, 2'd0, 4'b0111, 4'b0000, 16'h0000);
    for (int k = 1; k <= 8; k++)
      add(0,1, 32'h11,32'hEE,32'h11,32'h11, 32'h11,1,1,1,0, (k == 8) ? 2'd1 : 2'd0,
          4'b0111, (k == 8) ? 4'b0010 : 4'b0000, 16'(k << 4));
    add(0,0, 0,0,0,0, 32'h11,0,0,0,0, 2'd0, 4'b1101, 4'b0010, 16'h0080);
    for (int j = 1; j <= 8; j++)
      add(0,1, 32'h22,32'h55,32'h99,32'h22, 32'h22,1,1,1,0, (j == 8) ? 2'd1 : 2'd0,
          4'b1101, (j == 8) ? 4'b0110 : 4'b0010, 16'(16'h0080 | (j << 8)));
    add(0,0, 0,0,0,0, 32'h22,0,0,0,0, 2'd2, 4'b1001, 4'b0110, 16'h0880);
    add(0,1, 0,7,7,3, 0,1,1,0,1, 2'd2, 4'b1001, 4'b0110, 16'h0880);
    add(0,1, 5,7,7,5, 5,1,0,0,0, 2'd2, 4'b1001, 4'b0110, 16'h0880);
    add(1,0, 0,0,0,0, 0,0,0,0,0, 2'd0, 4'b0111, 4'b0000, 16'h0000);
    add(0,1, 4,4,9,4, 4,1,1,1,0, 2'd0, 4'b0111, 4'b0000, 16'h0100);
    add(0,1, 1,2,3,0, 1,1,1,0,1, 2'd0, 4'b0111, 4'b0000, 16'h0100);
    add(0,0, 0,0,0,0, 1,0,0,0,0, 2'd0, 4'b0111, 4'b0000, 16'h0100);

    foreach (tbl[i]) begin
      step_a(tbl[i].rst, tbl[i].vld, tbl[i].res);
      check($sformatf("t%0d.voted", i), 64'(voted), 64'(tbl[i].voted));
      check($sformatf("t%0d.flags", i), 64'({vvalid, det, cor, unc}),
            64'({tbl[i].vv, tbl[i].det, tbl[i].cor, tbl[i].unc}));
      check($sformatf("t%0d.state", i), 64'(st), 64'(tbl[i].st));
      check($sformatf("t%0d.en", i), 64'(en), 64'(tbl[i].en));
      check($sformatf("t%0d.faulty", i), 64'(faulty), 64'(tbl[i].f));
      check($sformatf("t%0d.cnt", i), 64'(cnt), 64'(tbl[i].cnt));
    end

    // ---------------- randomized run against the model ----------------
    model_reset();
    step_a(1, 0, '0);
    cmp_model(-1);
    bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = (cyc % 150 == 149);
      if (cyc % 40 == 0) bad = $urandom_range(0, NR - 1);
      v = ($urandom_range(0, 3) != 0);
      base = $urandom;
      for (int q = 0; q < NR; q++)
        res[q*DW +: DW] = ($urandom_range(0, 99) < ((q == bad) ? 75 : 4)) ? $urandom : base;
      step_a(r, v, res);
      model_step(r, v, res);
      cmp_model(cyc);
    end

    // ---------------- back-to-back swaps, NUM_REPL=5, THRESH=1 ----------------
    rb1 = {32'h10, 32'h10, 32'h10, 32'h20, 32'h10};
    rb2 = {32'h10, 32'h10, 32'h30, 32'h10, 32'h10};
    step_b(1, 0, '0);
    check("B.rst.en", 64'(en_b), 64'(5'b00111));
    check("B.rst.state", 64'(st_b), 64'(2'd0));
    step_b(0, 1, rb1);
    check("B.v1.state", 64'(st_b), 64'(2'd1));
    check("B.v1.faulty", 64'(faulty_b), 64'(5'b00010));
    check("B.v1.voted", 64'({voted_b, cor_b}), 64'({32'h10, 1'b1}));
    step_b(0, 1, rb2);
    check("B.v2.state", 64'(st_b), 64'(2'd1));
    check("B.v2.faulty", 64'(faulty_b), 64'(5'b00110));
    check("B.v2.en", 64'(en_b), 64'(5'b01101));
    step_b(0, 0, '0);
    check("B.done.state", 64'(st_b), 64'(2'd0));
    check("B.done.en", 64'(en_b), 64'(5'b11001));
    check("B.done.cnt", 64'(cnt_b), 64'(5'b00110));
    step_b(1, 0, '0);
    step_b(0, 1, rb1);
    step_b(0, 1, rb2);
    check("B.swap2.state", 64'(st_b), 64'(2'd1));
    step_b(1, 0, '0);
    check("B.rstswap.state", 64'(st_b), 64'(2'd0));
    check("B.rstswap.en", 64'(en_b), 64'(5'b00111));
    check("B.rstswap.faulty", 64'(faulty_b), 64'(5'b00000));
    check("B.rstswap.cnt", 64'(cnt_b), 64'(5'b00000));
    check("B.rstswap.out", 64'({voted_b, vvalid_b, det_b, cor_b, unc_b}), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
